// File: rtl/ex_stage.sv
// Execute stage: ALU, address and branch-condition evaluation, plus a
// 16-iteration shift-and-add multiplier that stalls the ID/EX register.
module ex_stage (
  input  logic        CLK_PIPE,
  input  logic        RST,
  input  logic [74:0] ID_EX,
  input  logic        FLUSH,
  output logic        STALL,
  output logic [59:0] EX_MEM
);

  localparam logic [5:0] OpAdd  = 6'h01;
  localparam logic [5:0] OpSub  = 6'h02;
  localparam logic [5:0] OpAnd  = 6'h03;
  localparam logic [5:0] OpOr   = 6'h04;
  localparam logic [5:0] OpXor  = 6'h05;
  localparam logic [5:0] OpSll  = 6'h06;
  localparam logic [5:0] OpSrl  = 6'h07;
  localparam logic [5:0] OpAddi = 6'h08;
  localparam logic [5:0] OpLw   = 6'h09;
  localparam logic [5:0] OpSw   = 6'h0A;
  localparam logic [5:0] OpBeqz = 6'h0B;
  localparam logic [5:0] OpBnez = 6'h0C;
  localparam logic [5:0] OpJ    = 6'h0D;
  localparam logic [5:0] OpMul  = 6'h10;

  typedef enum logic [0:0] {StRun, StMul} state_e;

  logic [15:0] reg_a, reg_b, imm, npc;
  logic [5:0]  opcd;
  logic [4:0]  rd;

  assign reg_a = ID_EX[74:59];
  assign reg_b = ID_EX[58:43];
  assign opcd  = ID_EX[42:37];
  assign rd    = ID_EX[36:32];
  assign imm   = ID_EX[31:16];
  assign npc   = ID_EX[15:0];

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] mcand_q, mcand_d;
  logic [15:0] mplier_q, mplier_d;
  // REG_B and RD of the multiply are held so the upstream bundle is free during MUL
  logic [15:0] mreg_b_q, mreg_b_d;
  logic [4:0]  mrd_q, mrd_d;
  logic [59:0] ex_mem_q, ex_mem_d;

  logic [15:0] res_alu, res_tgt;
  logic        res_cond, res_valid;
  logic [59:0] run_bundle;
  logic [15:0] mul_term, acc_sum;

  // Single-cycle result for the instruction currently presented on ID_EX
  always_comb begin
    res_alu   = '0;
    res_tgt   = '0;
    res_cond  = 1'b0;
    res_valid = 1'b1;
    case (opcd)
      OpAdd:               res_alu = reg_a + reg_b;
      OpSub:               res_alu = reg_a - reg_b;
      OpAnd:               res_alu = reg_a & reg_b;
      OpOr:                res_alu = reg_a | reg_b;
      OpXor:               res_alu = reg_a ^ reg_b;
      OpSll:               res_alu = reg_a << reg_b[3:0];
      OpSrl:               res_alu = reg_a >> reg_b[3:0];
      OpAddi, OpLw, OpSw:  res_alu = reg_a + imm;
      OpBeqz: begin
        res_tgt  = npc + imm;
        res_cond = (reg_a == 16'h0000);
      end
      OpBnez: begin
        res_tgt  = npc + imm;
        res_cond = (reg_a != 16'h0000);
      end
      OpJ: begin
        res_tgt  = npc + imm;
        res_cond = 1'b1;
      end
      default:             res_valid = 1'b0;
    endcase
    run_bundle = res_valid ? {res_alu, reg_b, opcd, rd, res_tgt, res_cond} : '0;
  end

  // Partial product added this iteration
  always_comb begin
    mul_term = mplier_q[0] ? mcand_q : 16'h0000;
    acc_sum  = acc_q + mul_term;
  end

  // Stall depends on state and inputs only; forced low while in reset
  always_comb begin
    STALL = RST & ~FLUSH &
            (((state_q == StRun) & (opcd == OpMul)) | ((state_q == StMul) & (cnt_q != 4'hF)));
  end

  // Next-state and EX/MEM bundle selection; FLUSH overrides everything
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    mreg_b_d = mreg_b_q;
    mrd_d    = mrd_q;
    ex_mem_d = '0;
    if (FLUSH) begin
      state_d = StRun;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StRun: begin
          if (opcd == OpMul) begin
            mcand_d  = reg_a;
            mplier_d = reg_b;
            acc_d    = '0;
            cnt_d    = '0;
            mreg_b_d = reg_b;
            mrd_d    = rd;
            state_d  = StMul;
          end else begin
            ex_mem_d = run_bundle;
          end
        end
        StMul: begin
          acc_d    = acc_sum;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 4'd1;
          if (cnt_q == 4'hF) begin
            ex_mem_d = {acc_sum, mreg_b_q, OpMul, mrd_q, 16'h0000, 1'b0};
            state_d  = StRun;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  // Pipeline and multiplier state registers
  always_ff @(posedge CLK_PIPE or negedge RST) begin
    if (!RST) begin
      state_q  <= StRun;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      mreg_b_q <= '0;
      mrd_q    <= '0;
      ex_mem_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      mreg_b_q <= mreg_b_d;
      mrd_q    <= mrd_d;
      ex_mem_q <= ex_mem_d;
    end
  end

  assign EX_MEM = ex_mem_q;

endmodule
